// File: rtl/serial_twos_complement.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_twos_complement
//  Purpose  : Bit-serial two's-complement negator with a start/ready
//             handshake. A parallel word is captured in IDLE, negated one bit
//             per cycle LSB-first with the copy-until-first-one-then-invert
//             rule, and the assembled result is committed to Out together
//             with a one-cycle out_valid pulse.
//  Ports    : clk        rising-edge clock
//             reset      asynchronous active-high reset, clears all state
//             start      load request, honoured only in IDLE
//             In         operand, captured on the accepting edge
//             ready      high while IDLE (also during reset)
//             Out        registered result (2^WIDTH - In) mod 2^WIDTH
//             out_valid  one-cycle pulse when Out is updated
//             overflow   registered with Out; set for the most-negative input
//             bit_out    current serial result bit
//             bit_valid  qualifies bit_out
//  Config   : SERIAL_OUT_EN  when defined, bit_out/bit_valid stream the
//             serial result; when undefined the serial output registers are
//             compiled out and both ports are tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module serial_twos_complement #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] In,
   output logic             ready,
   output logic [WIDTH-1:0] Out,
   output logic             out_valid,
   output logic             overflow,
   output logic             bit_out,
   output logic             bit_valid
);

   localparam int             CW         = $clog2(WIDTH);
   localparam logic [CW-1:0]  C_LAST     = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;    // remaining operand bits, next bit at [0]
   logic [WIDTH-1:0] res_q,   res_d;      // result assembled from the MSB end
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             seen_q,  seen_d;     // a '1' has been passed already
   logic             ovf_pend_q, ovf_pend_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic             ovf_q,   ovf_d;
   logic             out_valid_q, out_valid_d;

   logic             shift_b;
   logic             shift_o;

   // The first bit is produced on the load edge itself so that the registered
   // serial output is already valid in the first SHIFT cycle. Consequently, in
   // SHIFT the datapath always works one bit ahead of what bit_out shows.
   assign shift_b = shreg_q[0];
   assign shift_o = seen_q ? ~shift_b : shift_b;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      seen_d      = seen_q;
      ovf_pend_d  = ovf_pend_q;
      out_d       = out_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Bit 0 of a negation is always copied unchanged.
               shreg_d    = In >> 1;
               seen_d     = In[0];
               res_d      = {In[0], {(WIDTH-1){1'b0}}};
               cnt_d      = '0;
               ovf_pend_d = (In == C_MOST_NEG);
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_q == C_LAST) begin
               // res_q already holds all WIDTH bits at this point.
               out_d       = res_q;
               ovf_d       = ovf_pend_q;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               res_d   = {shift_o, res_q[WIDTH-1:1]};
               shreg_d = shreg_q >> 1;
               seen_d  = seen_q | shift_b;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         seen_q      <= 1'b0;
         ovf_pend_q  <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         seen_q      <= seen_d;
         ovf_pend_q  <= ovf_pend_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign Out       = out_q;
   assign overflow  = ovf_q;
   assign out_valid = out_valid_q;

`ifdef SERIAL_OUT_EN
   logic ser_bit_q,   ser_bit_d;
   logic ser_valid_q, ser_valid_d;

   always_comb begin
      ser_bit_d   = 1'b0;
      ser_valid_d = 1'b0;
      if (state_q == S_IDLE && start) begin
         ser_bit_d   = In[0];
         ser_valid_d = 1'b1;
      end else if (state_q == S_SHIFT && cnt_q != C_LAST) begin
         ser_bit_d   = shift_o;
         ser_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ser_bit_q   <= 1'b0;
         ser_valid_q <= 1'b0;
      end else begin
         ser_bit_q   <= ser_bit_d;
         ser_valid_q <= ser_valid_d;
      end
   end

   assign bit_out   = ser_bit_q;
   assign bit_valid = ser_valid_q;
`else
   assign bit_out   = 1'b0;
   assign bit_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_complement.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_twos_complement
//  Purpose  : Self-checking bench for serial_twos_complement (WIDTH=4).
//             Expected results come from plain modular arithmetic; serial
//             bits are the bits of the negated word taken LSB-first.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_twos_complement;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] In;
   logic         ready;
   logic [W-1:0] Out;
   logic         out_valid;
   logic         overflow;
   logic         bit_out;
   logic         bit_valid;

   int checks;
   int errors;
   logic [W-1:0] prev_out;
   logic         prev_ovf;

   serial_twos_complement #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .In        (In),
      .ready     (ready),
      .Out       (Out),
      .out_valid (out_valid),
      .overflow  (overflow),
      .bit_out   (bit_out),
      .bit_valid (bit_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] neg_of(input logic [W-1:0] v);
      int n;
      n = ((1 << W) - int'(v)) % (1 << W);
      return W'(n);
   endfunction

   function automatic logic ovf_of(input logic [W-1:0] v);
      return (int'(v) == (1 << (W - 1)));
   endfunction

   // One word through the block. Called at a negedge in IDLE; returns at the
   // negedge of the cycle where ready is back, so calls chain back-to-back.
   task automatic run_word(input logic [W-1:0] v, input int junk_cyc,
                           input logic [W-1:0] junk_val, input logic junk_done);
      logic [W-1:0] exp_out;
      logic         exp_ovf;
      exp_out = neg_of(v);
      exp_ovf = ovf_of(v);
      checks++;
      if (ready !== 1'b1) begin
         errors++; $display("FAIL ready_idle in=%h got %b want 1", v, ready);
      end
      start = 1'b1; In = v;
      @(negedge clk);
      for (int k = 1; k <= W; k++) begin
         if (k == junk_cyc) begin start = 1'b1; In = junk_val; end
         else begin start = 1'b0; In = W'($urandom); end
         checks++;
         if (ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL busy_flags in=%h cyc=%0d ready=%b out_valid=%b want 0,0", v, k, ready, out_valid);
         end
         checks++;
         if (Out !== prev_out || overflow !== prev_ovf) begin
            errors++; $display("FAIL out_hold in=%h cyc=%0d got %h/%b want %h/%b", v, k, Out, overflow, prev_out, prev_ovf);
         end
         checks++;
`ifdef SERIAL_OUT_EN
         if (bit_valid !== 1'b1 || bit_out !== exp_out[k-1]) begin
            errors++; $display("FAIL serial_bit in=%h cyc=%0d got v=%b b=%b want v=1 b=%b", v, k, bit_valid, bit_out, exp_out[k-1]);
         end
`else
         if (bit_valid !== 1'b0 || bit_out !== 1'b0) begin
            errors++; $display("FAIL serial_off in=%h cyc=%0d got v=%b b=%b want 0 0", v, k, bit_valid, bit_out);
         end
`endif
         @(negedge clk);
      end
      // cycle W+1: DONE
      start = junk_done; In = W'($urandom);
      checks++;
      if (out_valid !== 1'b1 || ready !== 1'b0) begin
         errors++; $display("FAIL done_flags in=%h out_valid=%b ready=%b want 1,0", v, out_valid, ready);
      end
      checks++;
      if (Out !== exp_out || overflow !== exp_ovf) begin
         errors++; $display("FAIL result in=%h got %h/%b want %h/%b", v, Out, overflow, exp_out, exp_ovf);
      end
      checks++;
      if (bit_valid !== 1'b0) begin
         errors++; $display("FAIL bit_valid_done in=%h got %b want 0", v, bit_valid);
      end
      @(negedge clk);
      // cycle W+2: IDLE again
      start = 1'b0;
      checks++;
      if (ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL ready_return in=%h ready=%b out_valid=%b want 1,0", v, ready, out_valid);
      end
      checks++;
      if (Out !== exp_out || overflow !== exp_ovf) begin
         errors++; $display("FAIL result_hold in=%h got %h/%b want %h/%b", v, Out, overflow, exp_out, exp_ovf);
      end
      prev_out = exp_out;
      prev_ovf = exp_ovf;
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (Out !== '0 || overflow !== 1'b0 || out_valid !== 1'b0 ||
          bit_out !== 1'b0 || bit_valid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL %s got Out=%h ovf=%b ov=%b bo=%b bv=%b rdy=%b want 0 0 0 0 0 1",
                  tag, Out, overflow, out_valid, bit_out, bit_valid, ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; In = '0;
      @(negedge clk);
      check_reset_values("reset_state");
      start = 1'b1; In = 4'b0101;    // start held during reset must not load
      @(negedge clk);
      check_reset_values("reset_held");
      start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check_reset_values("after_reset");
      prev_out = '0; prev_ovf = 1'b0;
   endtask

   task automatic test_basic();
      run_word(4'b0101, 0, '0, 1'b0);
      run_word(4'b0000, 0, '0, 1'b0);
      run_word(4'b1000, 0, '0, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_word(4'b0110, 2, 4'b0011, 1'b1);
      // No second pulse may follow from the ignored requests.
      for (int k = 0; k < W + 2; k++) begin
         checks++;
         if (out_valid !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL extra_pulse cyc=%0d out_valid=%b ready=%b want 0,1", k, out_valid, ready);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_abort();
      start = 1'b1; In = 4'b0111;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);              // cycle 2
      reset = 1'b1;
      #1;
      check_reset_values("abort_async");
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < W + 2; k++) begin
         check_reset_values("abort_quiet");
         @(negedge clk);
      end
      prev_out = '0; prev_ovf = 1'b0;
      run_word(4'b0001, 0, '0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int v = 0; v < (1 << W); v++) begin
         run_word(W'(v), 0, '0, 1'b0);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(negedge clk);
         run_word(W'($urandom), int'($urandom_range(0, W)), W'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      prev_out = '0;
      prev_ovf = 1'b0;
      test_reset();
      test_basic();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_twos_complement.md
# serial_twos_complement

Bit-serial two's-complement negator with a start/ready handshake. It accepts a parallel word, streams the negated value LSB-first using the copy-until-first-one, then-invert rule, and presents the assembled parallel result with a one-cycle valid pulse. It is the sequential counterpart of the combinational 4-bit two's-complement unit. It sits where a narrow serial datapath feeds negated operands to downstream arithmetic, and the combinational unit serves as its golden model.

## Interface
- WIDTH, 4, operand width in bits (>= 2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request to load In; sampled only in IDLE
- In  input  WIDTH  operand, captured on the clk edge where start=1 and state is IDLE
- ready  output  1  1 in IDLE (including during reset), else 0
- Out  output  WIDTH  registered result, (2^WIDTH − In) mod 2^WIDTH
- out_valid  output  1  one-cycle pulse when Out is updated
- overflow  output  1  registered with Out; 1 when In was the most-negative value (MSB=1, rest 0)
- bit_out  output  1  current serial result bit (see Configuration)
- bit_valid  output  1  qualifies bit_out (see Configuration)

## Operation
- One clock domain. Reset is asynchronous and active-high.
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1. When start=1 on an edge, load shreg←In, cnt←0, seen_one←0, and go to SHIFT.
- SHIFT, one bit per cycle, with b=shreg[0] and o = seen_one ? ~b : b:
  - bit_out=o and bit_valid=1.
  - The result register shifts o in at the MSB, then shreg>>1 and seen_one←seen_one|b.
  - cnt increments. On the edge where cnt==WIDTH−1, commit Out←assembled result and overflow←(In==10..0), then go to DONE.
- DONE: out_valid=1 for exactly one cycle, then go to IDLE.
- start while not in IDLE is ignored. In is not re-sampled.
- Out and overflow hold their value until the next commit. They do not change during SHIFT.
- Zero input gives Out=0, overflow=0. Most-negative input gives Out=In, overflow=1.
- cnt width is clog2(WIDTH). No wrap occurs because the FSM exits at WIDTH−1.

## Timing
- Reset values: state=IDLE, Out=0, overflow=0, out_valid=0, bit_out=0, bit_valid=0, ready=1.
- Cycle numbering: start is sampled at edge 0.
  - Serial bits are valid in cycles 1..WIDTH.
  - out_valid is high in cycle WIDTH+1.
  - ready returns in cycle WIDTH+2.
- Throughput is one word per WIDTH+2 cycles. start asserted during DONE is ignored.
- Reset asserted mid-operation aborts immediately: outputs go to reset values asynchronously, no out_valid is produced, and Out is not updated with a partial result.
- All outputs except ready are registered. ready is decoded from state.

## Configuration
- SERIAL_OUT_EN defined: bit_out and bit_valid behave as described in SHIFT.
- SERIAL_OUT_EN undefined:
  - The serial output logic is compiled out, and bit_out and bit_valid are tied to 0.
  - The ports remain, so the interface is unchanged.
  - Out, overflow and out_valid timing is identical.

## Test plan
- Cover all scenarios with WIDTH=4 and SERIAL_OUT_EN defined. Rerun scenario 1 with it undefined and require bit_valid=0 throughout.
1. Reset, then start with In=0101: bit_out is 1,1,0,1 in cycles 1–4; cycle 5 gives out_valid=1, Out=1011, overflow=0; ready=1 in cycle 6.
2. In=0000: bit_out is 0,0,0,0; Out=0000, overflow=0.
3. In=1000: bit_out is 0,0,0,1; Out=1000, overflow=1.
4. start with In=0110, then start=1 with In=0011 during cycle 2: the second request is ignored; Out=1010 with a single out_valid pulse.
5. Load In=0111, then pulse reset in cycle 2: outputs immediately take reset values and no out_valid occurs. A subsequent start with In=0001 gives Out=1111.
6. Sweep all 16 inputs back-to-back, starting each as soon as ready=1: every Out equals (16 − In) mod 16, and overflow=1 only for In=1000.
